// File: rtl/tile_mem_responder.sv
// Tile scratchpad: one read or write per cycle, with in-order read responses
// returned through a credit-limited FIFO so the consumer can apply backpressure.
module tile_mem_responder #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 24,
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_oor,
  output logic              busy,
  output logic              oor_err,
  input  logic              oor_clr
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int PL    = (READ_LAT > 1) ? READ_LAT - 1 : 1;
  localparam bit PIPED = (READ_LAT > 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  pipe_cnt;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_data [RSP_DEPTH];
  logic              fifo_oor  [RSP_DEPTH];
  logic              accept;
  logic              rd_acc;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;
  logic              push;
  logic              push_oor;
  logic [DATA_W-1:0] push_data;
  logic              pop;

  // Credit check looks only at internal counters, never at rsp_ready.
  assign in_range  = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
  assign req_ready = ({1'b0, pipe_cnt} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(RSP_DEPTH);
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && !req_we;
  assign rd_word   = in_range ? mem[req_addr[IDX_W-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (accept && req_we && in_range)
      mem[req_addr[IDX_W-1:0]] <= req_wdata;
  end

  // Stage p0 captures at the accepting edge; the last stage pushes into the FIFO.
  generate
    if (READ_LAT == 1) begin : g_direct
      assign push      = rd_acc;
      assign push_data = rd_word;
      assign push_oor  = !in_range;
    end else begin : g_pipe
      logic              vld_p  [PL];
      logic [DATA_W-1:0] data_p [PL];
      logic              oor_p  [PL];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PL; i++) vld_p[i] <= 1'b0;
        end else begin
          vld_p[0] <= rd_acc;
          for (int i = 1; i < PL; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_p[0] <= rd_word;
        oor_p[0]  <= !in_range;
        for (int i = 1; i < PL; i++) begin
          data_p[i] <= data_p[i-1];
          oor_p[i]  <= oor_p[i-1];
        end
      end

      assign push      = vld_p[PL-1];
      assign push_data = data_p[PL-1];
      assign push_oor  = oor_p[PL-1];
    end
  endgenerate

  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_oor   = rsp_valid ? fifo_oor[rd_ptr] : 1'b0;
  assign busy      = (pipe_cnt != '0) || (fifo_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_cnt <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      oor_err  <= 1'b0;
    end else begin
      pipe_cnt <= pipe_cnt + CNT_W'(rd_acc && PIPED) - CNT_W'(push && PIPED);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (accept && !in_range) oor_err <= 1'b1;
      else if (oor_clr)        oor_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_oor[wr_ptr]  <= push_oor;
    end
  end

endmodule

// File: tb/tb_tile_mem_responder.sv
// Directed bench for tile_mem_responder: latency, streaming, backpressure,
// out-of-range handling and reset with reads outstanding.
module tb_tile_mem_responder;
  localparam int DATA_W    = 24;
  localparam int ADDR_W    = 24;
  localparam int DEPTH     = 1024;
  localparam int LAT       = 2;
  localparam int RSP_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_ready = 1'b0;
  logic              oor_clr = 1'b0;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_oor;
  logic              busy;
  logic              oor_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tile_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_LAT(LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_oor(rsp_oor), .busy(busy), .oor_err(oor_err), .oor_clr(oor_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = ADDR_W'(a); req_wdata = DATA_W'(d);
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic read_issue(input int a);
    req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(a);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int nxt;

    repeat (3) tick();
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_oor",   rsp_oor, 0);
    check_eq("rst_busy",      busy, 0);
    check_eq("rst_oor_err",   oor_err, 0);
    rst = 1'b0;
    tick();

    write_word(5, 'h00ABCD);
    read_issue(5);
    check_eq("raw_not_yet_valid", rsp_valid, 0);
    check_eq("raw_busy", busy, 1);
    tick();
    check_eq("raw_valid", rsp_valid, 1);
    check_eq("raw_data", rsp_rdata, 'h00ABCD);
    check_eq("raw_oor", rsp_oor, 0);
    rsp_ready = 1'b1;
    tick();
    check_eq("raw_valid_after_pop", rsp_valid, 0);
    check_eq("raw_busy_after_pop", busy, 0);

    for (int i = 0; i < 16; i++) write_word(i, i * 3);

    rsp_ready = 1'b1;
    for (int k = 0; k < 16 + LAT; k++) begin
      if (k < 16) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(k);
        check_eq("stream_ready", req_ready, 1);
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (k >= LAT - 1 && k - (LAT - 1) < 16) begin
        check_eq("stream_valid", rsp_valid, 1);
        check_eq("stream_data", rsp_rdata, (k - (LAT - 1)) * 3);
      end
    end
    check_eq("stream_done_valid", rsp_valid, 0);
    check_eq("stream_done_busy", busy, 0);

    rsp_ready = 1'b0;
    acc = 0;
    nxt = 1;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(nxt);
      if (req_ready) begin
        acc++;
        nxt++;
      end
      tick();
    end
    check_eq("bp_accepted", acc, RSP_DEPTH);
    check_eq("bp_ready_low", req_ready, 0);
    check_eq("bp_valid", rsp_valid, 1);
    check_eq("bp_head", rsp_rdata, 3);
    tick();
    tick();
    check_eq("bp_head_hold", rsp_rdata, 3);
    check_eq("bp_ready_still_low", req_ready, 0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int j = 0; j < RSP_DEPTH; j++) begin
      check_eq("bp_drain_valid", rsp_valid, 1);
      check_eq("bp_drain_data", rsp_rdata, (1 + j) * 3);
      tick();
    end
    check_eq("bp_drained_valid", rsp_valid, 0);
    check_eq("bp_ready_back", req_ready, 1);

    rsp_ready = 1'b0;
    read_issue(DEPTH);
    tick();
    check_eq("oor_rd_valid", rsp_valid, 1);
    check_eq("oor_rd_data", rsp_rdata, 0);
    check_eq("oor_rd_flag", rsp_oor, 1);
    check_eq("oor_err_set", oor_err, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    write_word(DEPTH + 7, 'h123456);
    read_issue(7);
    tick();
    check_eq("oor_wr_dropped", rsp_rdata, 21);
    check_eq("inrange_oor_flag", rsp_oor, 0);
    check_eq("oor_err_sticky", oor_err, 1);
    rsp_ready = 1'b1;
    tick();
    oor_clr = 1'b1;
    read_issue(2000);
    oor_clr = 1'b0;
    check_eq("oor_set_beats_clr", oor_err, 1);
    tick();
    tick();
    check_eq("oor_drained", rsp_valid, 0);
    oor_clr = 1'b1;
    tick();
    oor_clr = 1'b0;
    check_eq("oor_cleared", oor_err, 0);

    write_word(9, 'h5A5A5A);
    rsp_ready = 1'b0;
    read_issue(5);
    read_issue(1500);
    read_issue(6);
    check_eq("mid_busy_before", busy, 1);
    check_eq("mid_oor_before", oor_err, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", rsp_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_oor_err", oor_err, 0);
    check_eq("mid_rst_ready", req_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    read_issue(9);
    tick();
    check_eq("retained_valid", rsp_valid, 1);
    check_eq("retained_data", rsp_rdata, 'h5A5A5A);
    rsp_ready = 1'b1;
    tick();
    check_eq("retained_busy_done", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
